// File: rtl/serial_xor_arbiter_if.sv
// rtl/serial_xor_arbiter_if.sv - request/operand/result bundle between two requesters and the serial XOR arbiter
interface serial_xor_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             z_owner;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, done, z, z_owner
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, done, z, z_owner
    );
endinterface

// File: rtl/serial_xor_arbiter.sv
// rtl/serial_xor_arbiter.sv - round-robin arbiter sharing one 1-bit xor_gate across two bit-serial XOR requests
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    xor u_xor (y, a, b);
endmodule

module serial_xor_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    serial_xor_arbiter_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             z_owner_q, z_owner_d;
    logic             owner_q, owner_d;
    logic             rr_last_q, rr_last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_w;
    logic             win;

    xor_gate u_xor_gate (
        .a (sh_a_q[0]),
        .b (sh_b_q[0]),
        .y (bit_w)
    );

    // Requester 1 wins when alone, or when both ask and requester 0 won last.
    assign win = bus.req1 & (~bus.req0 | ~rr_last_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        res_d     = res_q;
        z_d       = z_q;
        z_owner_d = z_owner_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_d   = SHIFT;
                    rr_last_d = win;
                    owner_d   = win;
                    sh_a_d    = win ? bus.a1 : bus.a0;
                    sh_b_d    = win ? bus.b1 : bus.b0;
                    cnt_d     = '0;
                    gnt0_d    = ~win;
                    gnt1_d    = win;
                end
            end
            SHIFT: begin
                sh_a_d = sh_a_q >> 1;
                sh_b_d = sh_b_q >> 1;
                res_d  = {bit_w, res_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    z_d       = {bit_w, res_q[WIDTH-1:1]};
                    z_owner_d = owner_q;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            res_q     <= '0;
            z_q       <= '0;
            z_owner_q <= 1'b0;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            res_q     <= res_d;
            z_q       <= z_d;
            z_owner_q <= z_owner_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.z       = z_q;
    assign bus.z_owner = z_owner_q;
endmodule
